// File: rtl/salsa20_pkg.sv
// Shared definitions for the iterative Salsa20 core: word geometry,
// quarterround rotation amounts, column/row word-index tables and the
// FSM state encoding.
package salsa20_pkg;

  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 16;
  localparam int STATE_W   = WORD_W * NUM_WORDS;

  // Rotation amounts of the four quarterround lines, in order.
  localparam int ROT_1 = 7;
  localparam int ROT_2 = 9;
  localparam int ROT_3 = 13;
  localparam int ROT_4 = 18;

  // Word indices (a, b, c, d) for each of the four quarterrounds of a round.
  localparam logic [0:3][0:3][3:0] COL_IDX = {
    4'd0,  4'd4,  4'd8,  4'd12,
    4'd5,  4'd9,  4'd13, 4'd1,
    4'd10, 4'd14, 4'd2,  4'd6,
    4'd15, 4'd3,  4'd7,  4'd11
  };

  localparam logic [0:3][0:3][3:0] ROW_IDX = {
    4'd0,  4'd1,  4'd2,  4'd3,
    4'd5,  4'd6,  4'd7,  4'd4,
    4'd10, 4'd11, 4'd8,  4'd9,
    4'd15, 4'd12, 4'd13, 4'd14
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_e;

  // Rotate a 32-bit word left by a constant amount (1..31).
  function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] x,
                                               input int unsigned n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

endpackage

// File: rtl/salsa20_qr_unit.sv
// One Salsa20 quarterround, purely combinational. Each line uses the word
// already updated by the line before it.
module salsa20_qr_unit
  import salsa20_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] c,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] a_new,
  output logic [WORD_W-1:0] b_new,
  output logic [WORD_W-1:0] c_new,
  output logic [WORD_W-1:0] d_new
);

  // Chained add-rotate-xor lines of the quarterround.
  always_comb begin
    b_new = b ^ rotl32(a + d, ROT_1);
    c_new = c ^ rotl32(b_new + a, ROT_2);
    d_new = d ^ rotl32(c_new + b_new, ROT_3);
    a_new = a ^ rotl32(d_new + c_new, ROT_4);
  end

endmodule

// File: rtl/salsa20_rounds.sv
// Iterative Salsa20 core: ROUNDS alternating column/row rounds computed with
// NUM_QR quarterround units, one step (NUM_QR quarterrounds) per clock.
// Optional macro SALSA20_ROUNDS_FEEDFORWARD_EN: when defined the input state
// is saved and added back at the end (standard core); when undefined the raw
// permutation is delivered with identical latency.
//
// Handshake: start is taken only on an edge where ready=1. ready drops on the
// accepting edge and rises together with valid on the final edge, L =
// ROUNDS*4/NUM_QR + 1 edges later. valid/data_out hold until the next accepted
// start, which clears valid immediately but leaves data_out until the next
// result is written.
module salsa20_rounds
  import salsa20_pkg::*;
#(
  parameter int NUM_QR = 1,
  parameter int ROUNDS = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [STATE_W-1:0] data_in,
  output logic               ready,
  output logic [STATE_W-1:0] data_out,
  output logic               valid,
  output logic [1:0]         dbg_state
);

  localparam int STEPS = 4 / NUM_QR;

  state_e                                   fsm;
  logic [NUM_WORDS-1:0][WORD_W-1:0]         st;
  logic [NUM_WORDS-1:0][WORD_W-1:0]         st_nx;
  logic [NUM_WORDS-1:0][WORD_W-1:0]         result;
  logic [1:0]                               step;
  logic [4:0]                               round;
  logic [NUM_QR-1:0][1:0]                   qk;
  logic [NUM_QR-1:0][3:0][3:0]              widx;
  logic [NUM_QR-1:0][3:0][WORD_W-1:0]       q_in;
  logic [NUM_QR-1:0][3:0][WORD_W-1:0]       q_out;

  assign dbg_state = fsm;

  // Pick the quarterrounds of the current step and gather their input words.
  always_comb begin
    qk   = '0;
    widx = '0;
    q_in = '0;
    for (int u = 0; u < NUM_QR; u++) begin
      qk[u] = 2'(int'(step) * NUM_QR + u);
      for (int p = 0; p < 4; p++) begin
        widx[u][p] = round[0] ? ROW_IDX[qk[u]][p] : COL_IDX[qk[u]][p];
        q_in[u][p] = st[widx[u][p]];
      end
    end
  end

  for (genvar g = 0; g < NUM_QR; g++) begin : g_qr
    salsa20_qr_unit u_qr (
      .a     (q_in[g][0]),
      .b     (q_in[g][1]),
      .c     (q_in[g][2]),
      .d     (q_in[g][3]),
      .a_new (q_out[g][0]),
      .b_new (q_out[g][1]),
      .c_new (q_out[g][2]),
      .d_new (q_out[g][3])
    );
  end

  // Write the quarterround outputs back in place; untouched words carry over.
  always_comb begin
    st_nx = st;
    for (int u = 0; u < NUM_QR; u++) begin
      for (int p = 0; p < 4; p++) begin
        st_nx[widx[u][p]] = q_out[u][p];
      end
    end
  end

`ifdef SALSA20_ROUNDS_FEEDFORWARD_EN
  logic [NUM_WORDS-1:0][WORD_W-1:0] saved;

  // Feed-forward: word-wise mod 2^32 addition of the saved input.
  always_comb begin
    result = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      result[i] = st[i] + saved[i];
    end
  end

  // Capture the input state on the accepting edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      saved <= '0;
    end else if (fsm == ST_IDLE && start) begin
      saved <= data_in;
    end
  end
`else
  // Raw permutation output.
  always_comb begin
    result = st;
  end
`endif

  // Control FSM with round/step counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm      <= ST_IDLE;
      st       <= '0;
      step     <= '0;
      round    <= '0;
      ready    <= 1'b1;
      valid    <= 1'b0;
      data_out <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (start) begin
            st    <= data_in;
            step  <= '0;
            round <= '0;
            valid <= 1'b0;
            ready <= 1'b0;
            fsm   <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          st <= st_nx;
          if (step == 2'(STEPS - 1)) begin
            step  <= '0;
            round <= round + 5'd1;
            if (round == 5'(ROUNDS - 1)) begin
              fsm <= ST_FINAL;
            end
          end else begin
            step <= step + 2'd1;
          end
        end
        ST_FINAL: begin
          data_out <= result;
          valid    <= 1'b1;
          ready    <= 1'b1;
          fsm      <= ST_IDLE;
        end
        default: begin
          fsm <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_salsa20_rounds.sv
// Bench for salsa20_rounds: five builds (NUM_QR/ROUNDS combinations) driven
// independently, a reference Salsa20 model feeding per-instance expected
// queues, and a negedge monitor that pops and compares on each valid rise.
module tb_salsa20_rounds;

  localparam int N = 5;

  logic         clk;
  logic         reset_n;
  logic         start [N];
  logic [511:0] din   [N];
  logic         rdy   [N];
  logic         vld   [N];
  logic [511:0] dout  [N];
  logic [1:0]   dbg   [N];

  logic [511:0] exp_q [N][$];
  logic [511:0] last_res [N];
  int           acc_cyc  [N];
  int           vcount   [N];
  logic         prev_vld [N];
  int           cyc;
  int           n_checks;
  int           n_fail;

  // Per-instance build parameters and the resulting latency.
  function automatic int rounds_of(input int i);
    case (i)
      3:       return 2;
      4:       return 8;
      default: return 20;
    endcase
  endfunction

  function automatic int qr_of(input int i);
    case (i)
      1:       return 2;
      2:       return 4;
      3:       return 2;
      4:       return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int lat_of(input int i);
    return rounds_of(i) * 4 / qr_of(i) + 1;
  endfunction

  salsa20_rounds #(.NUM_QR(1), .ROUNDS(20)) u_a (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .data_in(din[0]),
    .ready(rdy[0]), .data_out(dout[0]), .valid(vld[0]), .dbg_state(dbg[0]));
  salsa20_rounds #(.NUM_QR(2), .ROUNDS(20)) u_b (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .data_in(din[1]),
    .ready(rdy[1]), .data_out(dout[1]), .valid(vld[1]), .dbg_state(dbg[1]));
  salsa20_rounds #(.NUM_QR(4), .ROUNDS(20)) u_c (
    .clk(clk), .reset_n(reset_n), .start(start[2]), .data_in(din[2]),
    .ready(rdy[2]), .data_out(dout[2]), .valid(vld[2]), .dbg_state(dbg[2]));
  salsa20_rounds #(.NUM_QR(2), .ROUNDS(2)) u_d (
    .clk(clk), .reset_n(reset_n), .start(start[3]), .data_in(din[3]),
    .ready(rdy[3]), .data_out(dout[3]), .valid(vld[3]), .dbg_state(dbg[3]));
  salsa20_rounds #(.NUM_QR(4), .ROUNDS(8)) u_e (
    .clk(clk), .reset_n(reset_n), .start(start[4]), .data_in(din[4]),
    .ready(rdy[4]), .data_out(dout[4]), .valid(vld[4]), .dbg_state(dbg[4]));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] qr_f(input logic [31:0] a, b, c, d);
    logic [31:0] y1, y2, y3, y0;
    y1 = b ^ rl(a + d, 7);
    y2 = c ^ rl(y1 + a, 9);
    y3 = d ^ rl(y2 + y1, 13);
    y0 = a ^ rl(y3 + y2, 18);
    return {y0, y1, y2, y3};
  endfunction

  function automatic logic [511:0] salsa_model(input logic [511:0] x, input int rounds);
    logic [31:0]  y [16];
    logic [511:0] r;
    for (int i = 0; i < 16; i++) y[i] = x[32*i +: 32];
    for (int n = 0; n < rounds; n++) begin
      if (n % 2 == 0) begin
        {y[0],  y[4],  y[8],  y[12]} = qr_f(y[0],  y[4],  y[8],  y[12]);
        {y[5],  y[9],  y[13], y[1]}  = qr_f(y[5],  y[9],  y[13], y[1]);
        {y[10], y[14], y[2],  y[6]}  = qr_f(y[10], y[14], y[2],  y[6]);
        {y[15], y[3],  y[7],  y[11]} = qr_f(y[15], y[3],  y[7],  y[11]);
      end else begin
        {y[0],  y[1],  y[2],  y[3]}  = qr_f(y[0],  y[1],  y[2],  y[3]);
        {y[5],  y[6],  y[7],  y[4]}  = qr_f(y[5],  y[6],  y[7],  y[4]);
        {y[10], y[11], y[8],  y[9]}  = qr_f(y[10], y[11], y[8],  y[9]);
        {y[15], y[12], y[13], y[14]} = qr_f(y[15], y[12], y[13], y[14]);
      end
    end
    for (int i = 0; i < 16; i++) begin
`ifdef SALSA20_ROUNDS_FEEDFORWARD_EN
      r[32*i +: 32] = y[i] + x[32*i +: 32];
`else
      r[32*i +: 32] = y[i];
`endif
    end
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom_range(32'hffff_ffff, 0);
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset_n && vld[i] && !prev_vld[i]) begin
        vcount[i]++;
        if (exp_q[i].size() == 0) begin
          check($sformatf("unexpected_valid[%0d]", i), 512'd1, 512'd0);
        end else begin
          last_res[i] = exp_q[i].pop_front();
          check($sformatf("data_out[%0d]", i), dout[i], last_res[i]);
          check($sformatf("latency[%0d]", i), 512'(cyc - acc_cyc[i]), 512'(lat_of(i)));
          check($sformatf("ready_with_valid[%0d]", i), 512'(rdy[i]), 512'd1);
        end
      end
      prev_vld[i] = vld[i];
    end
  end

  // ---------------- driver tasks ----------------
  // Call at a negedge. Waits for ready, issues one start, queues the expected result.
  task automatic do_start(input int i, input logic [511:0] d);
    int n;
    n = 0;
    while (!rdy[i] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!rdy[i]) check($sformatf("ready_timeout[%0d]", i), 512'd0, 512'd1);
    start[i] = 1'b1;
    din[i]   = d;
    @(negedge clk);
    start[i]   = 1'b0;
    din[i]     = rand512();
    acc_cyc[i] = cyc;
    exp_q[i].push_back(salsa_model(d, rounds_of(i)));
    check($sformatf("ready_busy[%0d]", i), 512'(rdy[i]), 512'd0);
    check($sformatf("valid_cleared[%0d]", i), 512'(vld[i]), 512'd0);
    check($sformatf("data_out_held[%0d]", i), dout[i], last_res[i]);
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (exp_q[i].size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_q[i].size() != 0) begin
      check($sformatf("result_timeout[%0d]", i), 512'(exp_q[i].size()), 512'd0);
      exp_q[i].delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [511:0] d;
    logic [511:0] v;
    int           vc0;

    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    for (int i = 0; i < N; i++) begin
      start[i]    = 1'b0;
      din[i]      = '0;
      last_res[i] = '0;
      acc_cyc[i]  = 0;
      vcount[i]   = 0;
      prev_vld[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_ready[%0d]", i), 512'(rdy[i]), 512'd1);
      check($sformatf("rst_valid[%0d]", i), 512'(vld[i]), 512'd0);
      check($sformatf("rst_data_out[%0d]", i), dout[i], 512'd0);
      check($sformatf("rst_state[%0d]", i), 512'(dbg[i]), 512'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    // All-zero input on the default build.
    do_start(0, 512'd0);
    wait_idle(0);

    // Single-doubleround vector: word0 = 1, others 0.
    do_start(3, 512'd1);
    wait_idle(3);
`ifdef SALSA20_ROUNDS_FEEDFORWARD_EN
    check("doubleround_word0", 512'(dout[3][31:0]), 512'(32'h8186a22e));
`else
    check("doubleround_word0", 512'(dout[3][31:0]), 512'(32'h8186a22d));
`endif
    check("doubleround_word7", 512'(dout[3][255:224]), 512'(32'h00800000));

    // Same random inputs across NUM_QR = 1, 2, 4.
    for (int t = 0; t < 3; t++) begin
      d = rand512();
      for (int i = 0; i < 3; i++) do_start(i, d);
      for (int i = 0; i < 3; i++) wait_idle(i);
    end

    // Key/nonce/counter shaped state on the 20-round and 8-round builds.
    v = '0;
    v[31:0]    = 32'h61707865;
    v[191:160] = 32'h3320646e;
    v[351:320] = 32'h79622d32;
    v[511:480] = 32'h6b206574;
    for (int w = 1; w < 5; w++)   v[32*w +: 32] = {8'(4*w), 8'(4*w-1), 8'(4*w-2), 8'(4*w-3)};
    for (int w = 6; w < 10; w++)  v[32*w +: 32] = {8'(100+4*w), 8'(99+4*w), 8'(98+4*w), 8'(97+4*w)};
    for (int w = 11; w < 15; w++) v[32*w +: 32] = {8'(160+4*w), 8'(159+4*w), 8'(158+4*w), 8'(157+4*w)};
    do_start(0, v);
    do_start(4, v);
    wait_idle(0);
    wait_idle(4);

    // Back-to-back starts in the cycle valid rises.
    do_start(2, rand512());
    do_start(2, rand512());
    do_start(3, rand512());
    do_start(3, rand512());
    do_start(4, rand512());
    do_start(4, rand512());
    wait_idle(2);
    wait_idle(3);
    wait_idle(4);

    // Starts during a busy operation must be ignored.
    vc0 = vcount[0];
    do_start(0, rand512());
    repeat (3) @(negedge clk);
    start[0] = 1'b1;
    din[0]   = rand512();
    @(negedge clk);
    start[0] = 1'b0;
    repeat (34) @(negedge clk);
    start[0] = 1'b1;
    din[0]   = rand512();
    @(negedge clk);
    start[0] = 1'b0;
    wait_idle(0);
    repeat (100) @(negedge clk);
    check("single_valid_rise", 512'(vcount[0] - vc0), 512'd1);

    // Asynchronous reset in the middle of an operation.
    do_start(0, rand512());
    repeat (28) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_ready", 512'(rdy[0]), 512'd1);
    check("abort_valid", 512'(vld[0]), 512'd0);
    check("abort_data_out", dout[0], 512'd0);
    check("abort_state", 512'(dbg[0]), 512'd0);
    exp_q[0].delete();
    for (int i = 0; i < N; i++) last_res[i] = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_start(0, rand512());
    wait_idle(0);

    // Extra random traffic on the short builds.
    for (int t = 0; t < 6; t++) begin
      do_start(3, rand512());
      do_start(4, rand512());
    end
    wait_idle(3);
    wait_idle(4);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
